// File: rtl/alu_serial_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_serial_exec_pkg
// Shared definitions for the serial execute stage and the ALU control decoder:
// 3-bit ALU op codes, FSM state encoding and small op-classification helpers.
// -----------------------------------------------------------------------------
package alu_serial_exec_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_PASS = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // 100 and 111 are the only unassigned codes.
   function automatic logic op_is_illegal(input logic [2:0] op);
      return (op == 3'b100) || (op == 3'b111);
   endfunction

   // sub and slt both run as a + ~b + 1 through the adder.
   function automatic logic op_inverts_b(input logic [2:0] op);
      return (op == ALU_SUB) || (op == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu_serial_digit.sv
// -----------------------------------------------------------------------------
// alu_serial_digit
// Combinational datapath for one DIGIT-bit slice of the serial ALU.
//   a, b  : operand slices (b is already inverted for sub/slt)
//   cin   : carry into this slice
//   op    : ALU op code
//   y     : slice result
//   cout  : carry out of this slice (0 for logic/pass ops)
// -----------------------------------------------------------------------------
module alu_serial_digit
   import alu_serial_exec_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   input  logic [2:0]       op,
   output logic [DIGIT-1:0] y,
   output logic             cout
);

   logic [DIGIT:0] sum;

   always_comb begin
      // NOTE: every output gets a value before the case so no path can infer a latch.
      sum  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
      y    = sum[DIGIT-1:0];
      cout = 1'b0;
      case (op)
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         ALU_PASS: y = b;
         default:  cout = sum[DIGIT];  // add, sub, slt share the carry chain
      endcase
   end

endmodule

// File: rtl/alu_serial_exec.sv
// -----------------------------------------------------------------------------
// alu_serial_exec
// Multi-cycle execute stage: processes one op DIGIT bits per cycle, LSB first.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready high only in IDLE)
//   alu_control       : 3-bit op code
//   src_a, src_b      : operands
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   result            : registered result
//   zero              : result == 0
//   illegal           : op code was 100 or 111
// -----------------------------------------------------------------------------
module alu_serial_exec
   import alu_serial_exec_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [2:0]       op_r;
   logic             carry;
   logic [CW-1:0]    count;
   logic             a_msb;
   logic             b_msb;

   logic [DIGIT-1:0]       slice_y;
   logic                   slice_cout;
   logic [WIDTH+DIGIT-1:0] cat;
   logic [WIDTH-1:0]       shifted;
   logic                   lt;
   logic [WIDTH-1:0]       final_res;

   alu_serial_digit #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sr[DIGIT-1:0]),
      .b    (b_sr[DIGIT-1:0]),
      .cin  (carry),
      .op   (op_r),
      .y    (slice_y),
      .cout (slice_cout)
   );

   // New slice enters the result register from the top; the concat form also
   // covers DIGIT == WIDTH where result[WIDTH-1:DIGIT] would be empty.
   assign cat     = {slice_y, result};
   assign shifted = cat[WIDTH+DIGIT-1:DIGIT];

   // Signs differ: A is less iff A is negative. Signs equal: the difference
   // cannot overflow, so its sign bit (MSB of the final slice) decides.
   assign lt        = (a_msb != b_msb) ? a_msb : slice_y[DIGIT-1];
   assign final_res = (op_r == ALU_SLT) ? {{(WIDTH-1){1'b0}}, lt} : shifted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         op_r      <= ALU_ADD;
         carry     <= 1'b0;
         count     <= '0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  if (op_is_illegal(alu_control)) begin
                     result    <= '0;
                     zero      <= 1'b1;
                     illegal   <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     a_sr  <= src_a;
                     b_sr  <= op_inverts_b(alu_control) ? ~src_b : src_b;
                     carry <= op_inverts_b(alu_control);
                     op_r  <= alu_control;
                     a_msb <= src_a[WIDTH-1];
                     b_msb <= src_b[WIDTH-1];
                     count <= '0;
                     state <= S_BUSY;
                  end
               end
            end

            S_BUSY: begin
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               carry <= slice_cout;
               count <= count + 1'b1;
               if (count == LAST) begin
                  result    <= final_res;
                  zero      <= (final_res == '0);
                  illegal   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  result <= shifted;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_exec
// Scoreboard bench for alu_serial_exec: expected responses are queued at the
// accept edge and popped by an independent monitor at each output transfer.
// -----------------------------------------------------------------------------
module tb_alu_serial_exec;

   localparam int WIDTH  = 32;
   localparam int DIGIT  = 4;
   localparam int NSLICE = WIDTH / DIGIT;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             ill;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       alu_control = 3'b000;
   logic [WIDTH-1:0] src_a = '0;
   logic [WIDTH-1:0] src_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   logic rand_bp = 1'b0;

   alu_serial_exec #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: plain arithmetic on the whole word.
   function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
      exp_t e;
      e.ill = 1'b0;
      case (op)
         3'b000:  e.res = a + b;
         3'b001:  e.res = a - b;
         3'b010:  e.res = a | b;
         3'b011:  e.res = a & b;
         3'b101:  e.res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         3'b110:  e.res = b;
         default: begin e.res = '0; e.ill = 1'b1; end
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Caller is aligned 1 ns after a rising edge.
   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int waited = 0;
      while (!in_ready && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 64'(in_ready), 64'd1);
         return;
      end
      in_valid    = 1'b1;
      alu_control = op;
      src_a       = a;
      src_b       = b;
      @(posedge clk);
      sb.push_back(model(op, a, b));
      #1;
      in_valid    = 1'b0;
      alu_control = 3'($urandom);
      src_a       = $urandom;
      src_b       = $urandom;
   endtask

   // Rising edges seen after the accept edge until out_valid is observed.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return WIDTH'(1);
         2:       return '1;
         3:       return {1'b1, {(WIDTH-1){1'b0}}};
         4:       return {1'b0, {(WIDTH-1){1'b1}}};
         default: return $urandom;
      endcase
   endfunction

   // Monitor: a transfer happens at the next rising edge whenever both are high here.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result",  64'(result),  64'(e.res));
            check("zero",    64'(zero),    64'(e.z));
            check("illegal", 64'(illegal), 64'(e.ill));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b100, 3'b111};

      // Reset state
      #3;
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result),    64'd0);
      check("rst_zero",      64'(zero),      64'd0);
      check("rst_illegal",   64'(illegal),   64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Directed ops with latency checks on add and illegal
      issue(3'b000, 32'd5, 32'd7);
      wait_valid(lat);
      check("add_latency", 64'(lat), 64'(NSLICE));
      issue(3'b001, 32'd7, 32'd7);
      issue(3'b001, 32'd0, 32'd1);
      issue(3'b101, 32'hFFFF_FFFF, 32'd1);
      issue(3'b101, 32'h7FFF_FFFF, 32'h8000_0000);
      issue(3'b101, 32'd3, 32'd3);
      issue(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      issue(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      issue(3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      issue(3'b100, 32'd9, 32'd9);

      // Illegal op under backpressure
      while (out_valid) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_valid(lat);
      check("illegal_latency", 64'(lat), 64'd0);
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_result",    64'(result),    64'd0);
         check("bp_illegal",   64'(illegal),   64'd1);
         check("bp_in_ready",  64'(in_ready),  64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", 64'(out_valid), 64'd0);
      check("release_in_ready",  64'(in_ready),  64'd1);

      // Asynchronous reset at BUSY count=3: the queued response must never appear
      issue(3'b000, 32'd100, 32'd200);
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check("midop_out_valid", 64'(out_valid), 64'd0);
      check("midop_result",    64'(result),    64'd0);
      check("midop_in_ready",  64'(in_ready),  64'd0);
      void'(sb.pop_back());
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      issue(3'b000, 32'd1, 32'd1);

      // Randomised ops with random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) begin
         issue(ops[$urandom_range(0, 7)], rand_operand(), rand_operand());
      end

      // Drain
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
